// File: rtl/nrisc_int_pkg.sv
// Shared definitions for the NRISC interrupt controller: FSM state encoding,
// configuration register addresses and CTRL register bit positions.
package nrisc_int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } int_state_e;

    localparam logic [1:0] CFG_CTRL = 2'd0;
    localparam logic [1:0] CFG_MASK = 2'd1;
    localparam logic [1:0] CFG_EDGE = 2'd2;
    localparam logic [1:0] CFG_PEND = 2'd3;

    localparam int GIE_BIT = 0;

endpackage

// File: rtl/nrisc_int_ctrl_if.sv
// Bus between the NRISC core and its interrupt controller: the config
// register port plus the interrupt flag/acknowledge/end-of-interrupt handshake.
//
// Handshake: the controller raises INTERRUPT_flag with INTERRUPT_ch and keeps
// both stable until the core pulses int_ack for one cycle; the core pulses
// int_eoi for one cycle when the handler is done. int_ack is only honoured
// while a flag is outstanding, int_eoi only while a channel is in service.
interface nrisc_int_ctrl_if #(
    parameter int TAM  = 16,
    parameter int CH_W = 8
);
    logic            cfg_write;
    logic [1:0]      cfg_addr;
    logic [TAM-1:0]  cfg_wdata;
    logic [TAM-1:0]  cfg_rdata;
    logic            int_ack;
    logic            int_eoi;
    logic            INTERRUPT_flag;
    logic [CH_W-1:0] INTERRUPT_ch;

    // Core side
    modport master (
        output cfg_write, cfg_addr, cfg_wdata, int_ack, int_eoi,
        input  cfg_rdata, INTERRUPT_flag, INTERRUPT_ch
    );

    // Interrupt controller side
    modport slave (
        input  cfg_write, cfg_addr, cfg_wdata, int_ack, int_eoi,
        output cfg_rdata, INTERRUPT_flag, INTERRUPT_ch
    );
endinterface

// File: rtl/nrisc_int_prio_enc.sv
// Lowest-index-first priority encoder: idx is the lowest set bit of req,
// valid reports whether any bit is set (idx is 0 when none is).
module nrisc_int_prio_enc #(
    parameter int N_CH = 8,
    parameter int CH_W = 8
) (
    input  logic [N_CH-1:0] req,
    output logic [CH_W-1:0] idx,
    output logic            valid
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = CH_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nrisc_int_ctrl.sv
// NRISC interrupt controller: synchronises N_CH request lines, applies
// per-channel edge/level detection, mask and global enable, and hands the
// lowest-index request to the core through the flag/ack/eoi handshake.
// Build option NRISC_INT_NEST_EN enables nested interrupts: a lower-index
// request preempts the channels in service and in_service becomes a stack
// retired lowest-bit-first by int_eoi.
module nrisc_int_ctrl
    import nrisc_int_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int TAM  = 16,
    parameter int CH_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  irq_in,
    output logic [N_CH-1:0]  in_service,
    output int_state_e       state_dbg,
    nrisc_int_ctrl_if.slave  bus
);

    logic            gie_q;
    logic [N_CH-1:0] mask_q, edge_q;
    logic [N_CH-1:0] sync1_q, sync2_q, prev_q;
    logic [N_CH-1:0] pend_q, pend_d, pend_clr, rise, ack_clr;
    logic [N_CH-1:0] req_vec;
    logic [CH_W-1:0] req_idx;
    logic            req_valid;

    int_state_e      state_q, state_d;
    logic            flag_q, flag_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [N_CH-1:0] isr_q, isr_d;

    logic            pend_wr;

    // Configuration registers; a write lands on the next edge in any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gie_q  <= 1'b0;
            mask_q <= '0;
            edge_q <= '0;
        end else if (bus.cfg_write) begin
            case (bus.cfg_addr)
                CFG_CTRL: gie_q  <= bus.cfg_wdata[GIE_BIT];
                CFG_MASK: mask_q <= bus.cfg_wdata[N_CH-1:0];
                CFG_EDGE: edge_q <= bus.cfg_wdata[N_CH-1:0];
                default:  ;
            endcase
        end
    end

    // Combinational register read, zero-extended to the data width.
    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            CFG_CTRL: bus.cfg_rdata = TAM'(gie_q);
            CFG_MASK: bus.cfg_rdata = TAM'(mask_q);
            CFG_EDGE: bus.cfg_rdata = TAM'(edge_q);
            default:  bus.cfg_rdata = TAM'(pend_q);
        endcase
    end

    // Two-flop synchroniser per line, plus the previous synchronised value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Acknowledge clears the edge-pending bit of the frozen channel.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            ack_clr[i] = (state_q == ST_REQ) && bus.int_ack && (ch_q == CH_W'(i));
        end
    end

    // Edge channels latch a rising edge (set beats clear); level channels
    // follow the synchronised line and ignore PEND writes.
    always_comb begin
        pend_wr  = bus.cfg_write && (bus.cfg_addr == CFG_PEND);
        rise     = sync2_q & ~prev_q;
        pend_clr = ack_clr | (pend_wr ? bus.cfg_wdata[N_CH-1:0] : '0);
        pend_d   = (edge_q & (rise | (pend_q & ~pend_clr))) | (~edge_q & sync2_q);
        req_vec  = pend_q & mask_q & {N_CH{gie_q}};
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_q <= '0;
        else      pend_q <= pend_d;
    end

    nrisc_int_prio_enc #(.N_CH(N_CH), .CH_W(CH_W)) u_req_enc (
        .req   (req_vec),
        .idx   (req_idx),
        .valid (req_valid)
    );

`ifdef NRISC_INT_NEST_EN
    logic [CH_W-1:0] isr_idx;
    logic            isr_valid;
    logic [N_CH-1:0] isr_pop;

    nrisc_int_prio_enc #(.N_CH(N_CH), .CH_W(CH_W)) u_isr_enc (
        .req   (isr_q),
        .idx   (isr_idx),
        .valid (isr_valid)
    );

    // in_service with its lowest set bit (the innermost handler) removed.
    assign isr_pop = isr_q & (isr_q - N_CH'(1));
`endif

    // FSM next state and flag/channel/in_service updates.
    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        ch_d    = ch_q;
        isr_d   = isr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_REQ;
                    flag_d  = 1'b1;
                    ch_d    = req_idx;
                end
            end
            ST_REQ: begin
                // Flag and channel stay frozen until the core takes them.
                if (bus.int_ack) begin
                    state_d = ST_SERV;
                    flag_d  = 1'b0;
                    isr_d   = isr_q | ack_clr;
                end
            end
            ST_SERV: begin
`ifdef NRISC_INT_NEST_EN
                if (bus.int_eoi) begin
                    isr_d   = isr_pop;
                    state_d = (isr_pop != '0) ? ST_SERV : ST_IDLE;
                end else if (req_valid && isr_valid && (req_idx < isr_idx)) begin
                    state_d = ST_REQ;
                    flag_d  = 1'b1;
                    ch_d    = req_idx;
                end
`else
                if (bus.int_eoi) begin
                    isr_d   = '0;
                    state_d = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            flag_q  <= 1'b0;
            ch_q    <= '0;
            isr_q   <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            ch_q    <= ch_d;
            isr_q   <= isr_d;
        end
    end

    assign bus.INTERRUPT_flag = flag_q;
    assign bus.INTERRUPT_ch   = ch_q;
    assign in_service         = isr_q;
    assign state_dbg          = state_q;

endmodule
